// File: rtl/mc14500_sequencer.sv
// mc14500_sequencer: fetches program words and drives the ICU request handshake.
// Define MC14500_SEQ_RET_STACK_EN to add a JMP/RTN return-address stack.
package mc14500_pkg;
    typedef enum logic [3:0] {
        NOPO = 4'h0, LD, LDC, AND, ANDC, OR, ORC, XNOR,
        STO, STOC, IEN, OEN, JMP, RTN, SKZ, NOPF
    } instruction_t;
endpackage

module mc14500_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [ADDR_W+3:0] prog_data,
    output instruction_t      instruction,
    output logic              req,
    input  logic              ack,
    input  logic              jmp,
    input  logic              rtn,
    input  logic              flag_o,
    input  logic              flag_f,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_o_pulse,
    output logic              halted,
    output logic              stack_err
);
    typedef enum logic [2:0] {FETCH, LATCH, REQ, REL, EVAL, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] opnd_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;

    assign pc_inc = pc + ADDR_W'(1);

`ifdef MC14500_SEQ_RET_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic              full;
    logic              empty;

    assign sp_dec = sp - SP_W'(1);
    assign full   = (sp == SP_W'(STACK_DEPTH));
    assign empty  = (sp == '0);

    always_comb begin
        next_pc = pc_inc;
        if (jmp)
            next_pc = opnd_q;
        else if (rtn && !empty)
            next_pc = stack_mem[IDX_W'(sp_dec)];
    end
`else
    // Without the stack a return is plain sequential flow.
    always_comb begin
        next_pc = pc_inc;
        if (jmp)
            next_pc = opnd_q;
        else if (rtn)
            next_pc = pc_inc;
    end

    assign stack_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= '0;
            prog_addr    <= '0;
            instruction  <= NOPO;
            opnd_q       <= '0;
            req          <= 1'b0;
            flag_o_pulse <= 1'b0;
            halted       <= 1'b0;
`ifdef MC14500_SEQ_RET_STACK_EN
            sp           <= '0;
            stack_err    <= 1'b0;
`endif
        end else begin
            flag_o_pulse <= 1'b0;
            unique case (state)
                FETCH: begin
                    prog_addr <= pc;
                    state     <= LATCH;
                end
                LATCH: begin
                    instruction <= instruction_t'(prog_data[3:0]);
                    opnd_q      <= prog_data[ADDR_W+3:4];
                    req         <= 1'b1;
                    state       <= REQ;
                end
                REQ: begin
                    if (ack) begin
                        req   <= 1'b0;
                        state <= REL;
                    end
                end
                REL: begin
                    if (!ack)
                        state <= EVAL;
                end
                EVAL: begin
                    flag_o_pulse <= flag_o;
                    if (flag_f) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        // Address the next word now so it is ready by LATCH.
                        pc        <= next_pc;
                        prog_addr <= next_pc;
                        state     <= FETCH;
`ifdef MC14500_SEQ_RET_STACK_EN
                        if (jmp) begin
                            if (full) begin
                                stack_err <= 1'b1;
                            end else begin
                                stack_mem[IDX_W'(sp)] <= pc_inc;
                                sp <= sp + SP_W'(1);
                            end
                        end else if (rtn) begin
                            if (empty)
                                stack_err <= 1'b1;
                            else
                                sp <= sp_dec;
                        end
`endif
                    end
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
